// File: rtl/regfile_pkg.sv
// Shared widths, select codes and control levels for the register file.
package regfile_pkg;
  localparam int RegBus     = 16;
  localparam int RegAddrBus = 3;
  localparam int SREG_N     = 4;

  localparam logic RstEnable = 1'b1;
  localparam logic Enable    = 1'b1;
  localparam logic Disable   = 1'b0;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    SREG_SP = 2'd0,
    SREG_IH = 2'd1,
    SREG_T  = 2'd2,
    SREG_RA = 2'd3
  } sreg_e;

  typedef struct packed {
    logic                  re;
    logic [RegAddrBus-1:0] addr;
  } rd_req_t;
endpackage

// File: rtl/regfile_if.sv
// Write-back, decode-read and special-register bus of the register file.
interface regfile_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
);
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [AW-1:0]     raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [AW-1:0]     raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              swe;
  logic [1:0]        swsel;
  logic [DATA_W-1:0] swdata;
  logic [1:0]        srsel;
  logic [DATA_W-1:0] srdata;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, swe, swsel, swdata, srsel,
    input  rdata1, rdata2, srdata
  );
  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, swe, swsel, swdata, srsel,
    output rdata1, rdata2, srdata
  );
endinterface

// File: rtl/regfile_rdport.sv
// One GPR read port: enable gate, write-to-read bypass, then array select.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int GPR_N  = 8
) (
  input  logic                           rst,
  input  rd_req_t                        req,
  input  logic                           we,
  input  logic [RegAddrBus-1:0]          waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [GPR_N-1:0][DATA_W-1:0]   gpr,
  output logic [DATA_W-1:0]              rdata
);
  always_comb begin
    rdata = '0;
    if (rst != RstEnable && req.re == Enable) begin
      if (we == Enable && waddr == req.addr) rdata = wdata;
      else                                   rdata = gpr[req.addr];
    end
  end
endmodule

// File: rtl/regfile.sv
// Eight-entry GPR file with two bypassed read ports plus SP/IH/T/RA specials.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int GPR_N  = 8
) (
  input  logic     clk,
  input  logic     rst,
  regfile_if.slave bus
);
  localparam int NPORT = 2;

  logic [GPR_N-1:0][DATA_W-1:0]  gpr;
  logic [SREG_N-1:0][DATA_W-1:0] sreg;
  rd_req_t [NPORT-1:0]           req;
  logic [NPORT-1:0][DATA_W-1:0]  rdata;

  // GPR and special arrays are independent, so both writes may land together.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      gpr  <= '0;
      sreg <= '0;
    end else begin
      if (bus.we == Enable)  gpr[bus.waddr]  <= bus.wdata;
      if (bus.swe == Enable) sreg[bus.swsel] <= bus.swdata;
    end
  end

  assign req[0] = '{re: bus.re1, addr: bus.raddr1};
  assign req[1] = '{re: bus.re2, addr: bus.raddr2};

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    regfile_rdport #(.DATA_W(DATA_W), .GPR_N(GPR_N)) u_rd (
      .rst   (rst),
      .req   (req[p]),
      .we    (bus.we),
      .waddr (bus.waddr),
      .wdata (bus.wdata),
      .gpr   (gpr),
      .rdata (rdata[p])
    );
  end

  assign bus.rdata1 = rdata[0];
  assign bus.rdata2 = rdata[1];

  always_comb begin
    bus.srdata = '0;
    if (rst != RstEnable) begin
      if (bus.swe == Enable && bus.swsel == bus.srsel) bus.srdata = bus.swdata;
      else                                             bus.srdata = sreg[bus.srsel];
    end
  end
endmodule

// File: tb/tb_regfile.sv
// Directed vector table plus reset/fill sequences for the register file.
module tb_regfile;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  regfile_if #(.DATA_W(16), .AW(3)) bus ();

  regfile #(.DATA_W(16), .GPR_N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        re1;
    logic [2:0]  raddr1;
    logic        re2;
    logic [2:0]  raddr2;
    logic        swe;
    logic [1:0]  swsel;
    logic [15:0] swdata;
    logic [1:0]  srsel;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] es;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.we = 0; bus.waddr = 0; bus.wdata = 0;
    bus.re1 = 0; bus.raddr1 = 0; bus.re2 = 0; bus.raddr2 = 0;
    bus.swe = 0; bus.swsel = 0; bus.swdata = 0; bus.srsel = 0;
  endtask

  initial begin
    //            rst we wa wdata     re1 a1 re2 a2 swe ss swdata    sr  e1        e2        es
    vecs[0]  = '{1, 1, 2, 16'hAAAA, 1, 2, 1, 2, 1, 0, 16'h5555, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[1]  = '{0, 0, 0, 16'h0000, 1, 2, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000};
    vecs[2]  = '{0, 1, 3, 16'hBEEF, 1, 3, 1, 2, 0, 0, 16'h0000, 0, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[3]  = '{0, 0, 0, 16'h0000, 1, 3, 0, 3, 0, 0, 16'h0000, 0, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[4]  = '{0, 1, 5, 16'h0001, 1, 5, 0, 0, 0, 0, 16'h0000, 0, 16'h0001, 16'h0000, 16'h0000};
    vecs[5]  = '{0, 1, 5, 16'h00FF, 1, 5, 1, 5, 0, 0, 16'h0000, 0, 16'h00FF, 16'h00FF, 16'h0000};
    vecs[6]  = '{0, 0, 0, 16'h0000, 1, 5, 1, 5, 0, 0, 16'h0000, 0, 16'h00FF, 16'h00FF, 16'h0000};
    vecs[7]  = '{0, 1, 0, 16'h7777, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h7777, 16'h0000, 16'h0000};
    vecs[8]  = '{0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h7777, 16'h0000, 16'h0000};
    vecs[9]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 3, 16'h1111, 3, 16'h0000, 16'h0000, 16'h1111};
    vecs[10] = '{0, 1, 7, 16'hCAFE, 1, 7, 1, 3, 1, 0, 16'hBF00, 0, 16'hCAFE, 16'hBEEF, 16'hBF00};
    vecs[11] = '{0, 0, 0, 16'h0000, 1, 7, 1, 5, 0, 0, 16'h0000, 0, 16'hCAFE, 16'h00FF, 16'hBF00};
    vecs[12] = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 3, 16'h0000, 16'h0000, 16'h1111};
    vecs[13] = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 16'h2222, 3, 16'h0000, 16'h0000, 16'h1111};
    vecs[14] = '{0, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 2, 16'h3333, 1, 16'h0000, 16'h0000, 16'h2222};
    vecs[15] = '{0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0000, 2, 16'h7777, 16'h0000, 16'h3333};

    idle();
    rst = 1;
    @(posedge clk);
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      bus.we = vecs[i].we; bus.waddr = vecs[i].waddr; bus.wdata = vecs[i].wdata;
      bus.re1 = vecs[i].re1; bus.raddr1 = vecs[i].raddr1;
      bus.re2 = vecs[i].re2; bus.raddr2 = vecs[i].raddr2;
      bus.swe = vecs[i].swe; bus.swsel = vecs[i].swsel; bus.swdata = vecs[i].swdata;
      bus.srsel = vecs[i].srsel;
      #1;
      chk($sformatf("vec%0d rdata1", i), bus.rdata1, vecs[i].e1);
      chk($sformatf("vec%0d rdata2", i), bus.rdata2, vecs[i].e2);
      chk($sformatf("vec%0d srdata", i), bus.srdata, vecs[i].es);
      @(posedge clk);
    end

    // Fill every register with 0x1234, then reset and confirm all reads clear.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle();
      bus.we = 1; bus.waddr = 3'(i); bus.wdata = 16'h1234;
      if (i < 4) begin
        bus.swe = 1; bus.swsel = 2'(i); bus.swdata = 16'h1234;
      end
      @(posedge clk);
    end
    @(negedge clk);
    idle();
    bus.re1 = 1; bus.raddr1 = 6; bus.re2 = 1; bus.raddr2 = 0; bus.srsel = 2;
    #1;
    chk("fill rdata1", bus.rdata1, 16'h1234);
    chk("fill rdata2", bus.rdata2, 16'h1234);
    chk("fill srdata", bus.srdata, 16'h1234);

    @(negedge clk);
    rst = 1;
    bus.we = 1; bus.waddr = 6; bus.wdata = 16'h9999;
    bus.swe = 1; bus.swsel = 2; bus.swdata = 16'h9999;
    #1;
    chk("in-reset rdata1", bus.rdata1, 16'h0000);
    chk("in-reset rdata2", bus.rdata2, 16'h0000);
    chk("in-reset srdata", bus.srdata, 16'h0000);
    @(posedge clk);

    @(negedge clk);
    rst = 0;
    idle();
    for (int i = 0; i < 8; i++) begin
      bus.re1 = 1; bus.raddr1 = 3'(i);
      bus.re2 = 1; bus.raddr2 = 3'(7 - i);
      bus.srsel = 2'(i % 4);
      #1;
      chk($sformatf("clr R%0d p1", i), bus.rdata1, 16'h0000);
      chk($sformatf("clr R%0d p2", 7 - i), bus.rdata2, 16'h0000);
      chk($sformatf("clr S%0d", i % 4), bus.srdata, 16'h0000);
    end

    // First edge after reset release writes normally.
    idle();
    bus.we = 1; bus.waddr = 4; bus.wdata = 16'h4242;
    @(posedge clk);
    @(negedge clk);
    idle();
    bus.re1 = 1; bus.raddr1 = 4; bus.re2 = 1; bus.raddr2 = 4;
    #1;
    chk("post-rst R4 p1", bus.rdata1, 16'h4242);
    chk("post-rst R4 p2", bus.rdata2, 16'h4242);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_W, default 16: register data width; matches RegBus.
REQ-002 Parameter GPR_N, default 8: number of general registers R0..R7; GPR addresses are 3 bits, matching RegAddrBus.
REQ-003 Port clk  in  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  in  1: synchronous, active-high reset (RstEnable = 1), sampled on the rising clk edge.
REQ-005 Port we  in  1: GPR write enable from write-back.
REQ-006 Port waddr  in  3: GPR write address.
REQ-007 Port wdata  in  DATA_W: GPR write data.
REQ-008 Port re1  in  1: read-port-1 enable, driven by the decode stage's reg1 read enable.
REQ-009 Port raddr1  in  3: read-port-1 address.
REQ-010 Port rdata1  out  DATA_W: read-port-1 data, returned to the decode stage as its reg1 data input.
REQ-011 Port re2  in  1: read-port-2 enable.
REQ-012 Port raddr2  in  3: read-port-2 address.
REQ-013 Port rdata2  out  DATA_W: read-port-2 data.
REQ-014 Port swe  in  1: special-register write enable.
REQ-015 Port swsel  in  2: special-register write select; 0=SP, 1=IH, 2=T, 3=RA.
REQ-016 Port swdata  in  DATA_W: special-register write data.
REQ-017 Port srsel  in  2: special-register read select, same encoding as swsel.
REQ-018 Port srdata  out  DATA_W: special-register read data.

Function
REQ-019 GPR write: when we=1 and rst=0, R[waddr] SHALL take wdata at the rising edge, becoming visible in the register array one cycle later.
REQ-020 Special-register write: when swe=1 and rst=0, the register selected by swsel SHALL take swdata at the rising edge.
REQ-021 Reads SHALL be combinational, with zero-cycle latency from address to data.
REQ-022 Port-1 priority chain:
  - re1=0 -> rdata1 = 0.
  - else if we=1 and waddr=raddr1 -> rdata1 = wdata (write-to-read bypass).
  - else -> rdata1 = R[raddr1].
REQ-023 Port 2 SHALL follow the identical priority chain, using re2 and raddr2.
REQ-024 srdata SHALL select between bypass and array: if swe=1 and swsel=srsel, srdata = swdata; otherwise srdata = the selected special register.
REQ-025 R0 SHALL be an ordinary writable register; no hardwired zero.
REQ-026 Both read ports SHALL be independent; both addressing the same register, including the bypassed one, SHALL return identical data.
REQ-027 GPR and special-register writes in the same cycle SHALL both commit, since they are independent arrays.
REQ-028 Bypass SHALL be suppressed while rst=1, because reads return 0 during reset.
REQ-029 All read outputs SHALL be 0 while rst=1, regardless of enables.
REQ-030 No internal state besides the register arrays; no stall or handshake signals.

Reset
REQ-031 A rising edge with rst=1 SHALL clear R0..R7, SP, IH, T and RA to 0.
REQ-032 A write asserted in the same cycle as rst=1 SHALL be discarded.
REQ-033 On reset deassertion, the first edge with we=1 SHALL write normally; no recovery cycles are required.

Structure
REQ-034 The shared defines file SHALL hold:
  - RegBus and RegAddrBus.
  - The special-register select codes SREG_SP, SREG_IH, SREG_T, SREG_RA.
  - RstEnable, Enable, Disable and ZeroWord.
REQ-035 A single sub-module, regfile_rdport, SHALL implement the enable/bypass/array-select mux and be instantiated twice for the GPR ports.
REQ-036 The special-register read path SHALL be written inline in regfile, not through regfile_rdport.

Verification
REQ-037 Reset clear:
  - Stimulus: write 0x1234 to all of R0..R7, SP, IH, T and RA; then rst=1 for one edge.
  - Response: every read (re=1) and srdata returns 0x0000.
REQ-038 Basic write/read: we=1, waddr=3, wdata=0xBEEF, one edge; next cycle re1=1, raddr1=3 -> rdata1=0xBEEF.
REQ-039 Bypass:
  - Stimulus: R5=0x0001 stored; same cycle we=1, waddr=5, wdata=0x00FF, re1=re2=1, raddr1=raddr2=5.
  - Response: rdata1=rdata2=0x00FF; after the edge the array holds 0x00FF.
REQ-040 Read disable: re2=0 with raddr2 pointing at a register holding 0x7777 -> rdata2=0x0000, including when a bypass would match.
REQ-041 Special registers:
  - Stimulus: swe=1, swsel=0 (SP), swdata=0xBF00 with srsel=0 in the same cycle.
  - Response: srdata=0xBF00 via bypass; next cycle with swe=0, srsel=0 -> 0xBF00; srsel=3 -> RA's value, unchanged.
REQ-042 Write during reset: rst=1, we=1, waddr=2, wdata=0xAAAA at one edge; next cycle rst=0, re1=1, raddr1=2 -> rdata1=0x0000.
